gf233_mult_seq: RTL and testbench



---
 rtl/gf233_mult_seq.sv | 124 ++++++++++++
 tb/tb_gf233_mult_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/gf233_mult_seq.sv
// Unreduced GF(2)[x] multiply of two M-bit operands, time-multiplexing one
// external WxW carry-less limb multiplier (registered, one-cycle latency).
module gf233_mult_seq #(
  parameter int M = 233,
  parameter int W = 29
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*M-2:0] c,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_d
);

  localparam int N  = (M + W - 1) / W;
  localparam int NW = N * W;
  localparam int AW = 2 * NW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [NW-1:0]   r_a, r_b;
  logic [AW-1:0]   r_acc, w_acc_next, w_pp;
  logic [CW-1:0]   r_i, r_j, r_id, r_jd;
  logic [CW-1:0]   w_i_nx, w_j_nx;
  logic [CW:0]     w_sum;
  logic            r_v;
  logic            r_busy, r_done;
  logic [2*M-2:0]  r_c;
  logic [W-1:0]    r_mul_a, r_mul_b;
  logic            w_accept, w_last, w_wrap;

  assign busy  = r_busy;
  assign done  = r_done;
  assign c     = r_c;
  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_wrap   = (r_j == CW'(N - 1));
  assign w_last   = w_wrap && (r_i == CW'(N - 1));
  assign w_j_nx   = w_wrap ? '0 : r_j + CW'(1);
  assign w_i_nx   = w_wrap ? r_i + CW'(1) : r_i;

  // Partial product lands at limb offset i_d + j_d (up to 2N-2, hence CW+1 bits)
  assign w_sum      = {1'b0, r_id} + {1'b0, r_jd};
  assign w_pp       = {{(AW - 2*W){1'b0}}, mul_d} << (W * w_sum);
  assign w_acc_next = r_v ? (r_acc ^ w_pp) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_id    <= '0;
      r_jd    <= '0;
      r_v     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c     <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      // Valid tag qualifies mul_d one cycle after each issue
      r_v    <= (r_state == S_RUN);
      r_id   <= r_i;
      r_jd   <= r_j;
      r_busy <= (w_next == S_RUN) || (w_next == S_DRAIN);
      r_done <= (r_state == S_DRAIN);

      if (w_accept) begin
        r_a     <= NW'(a);
        r_b     <= NW'(b);
        r_acc   <= '0;
        r_i     <= '0;
        r_j     <= '0;
        r_mul_a <= a[W-1:0];
        r_mul_b <= b[W-1:0];
      end else begin
        r_acc <= w_acc_next;
        if (r_state == S_RUN) begin
          if (w_last) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
          end else begin
            r_i     <= w_i_nx;
            r_j     <= w_j_nx;
            r_mul_a <= r_a[W*w_j_nx +: W];
            r_mul_b <= r_b[W*w_i_nx +: W];
          end
        end
        if (r_state == S_DRAIN) r_c <= w_acc_next[2*M-2:0];
      end
    end
  end

  a_acc_top_zero: assert property (@(posedge clk) disable iff (!rst_n)
    r_acc[AW-1:2*M-1] == '0);

endmodule

// File: tb/tb_gf233_mult_seq.sv
// Directed bench for gf233_mult_seq with a behavioural 29x29 limb multiplier.
module tb_gf233_mult_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [232:0] a, b;
  logic         busy, done;
  logic [464:0] c;
  logic [28:0]  mul_a, mul_b;
  logic [57:0]  mul_d = '0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gf233_mult_seq #(.M(233), .W(29)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_d (mul_d)
  );

  function automatic logic [57:0] clmul29(input logic [28:0] x, input logic [28:0] y);
    logic [57:0] r;
    r = '0;
    for (int unsigned i = 0; i < 29; i++)
      if (y[i]) r ^= 58'(x) << i;
    return r;
  endfunction

  function automatic logic [464:0] clmul233(input logic [232:0] x, input logic [232:0] y);
    logic [464:0] r;
    r = '0;
    for (int unsigned i = 0; i < 233; i++)
      if (y[i]) r ^= 465'(x) << i;
    return r;
  endfunction

  // External limb multiplier: registered, no reset
  always @(posedge clk) mul_d <= clmul29(mul_a, mul_b);

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Caller is at a negedge; start is high for the following cycle T.
  task automatic run_op(input logic [232:0] ia, input logic [232:0] ib, input int inj_k,
                        output logic [464:0] oc, output int lat, output int nbusy);
    a = ia; b = ib; start = 1'b1;
    lat = 0; nbusy = 0; oc = '0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == inj_k) begin
        start = 1'b1; a = ~ia; b = ib ^ 233'h5;
      end
      if (k == inj_k + 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        lat = k; oc = c;
      end
    end
  endtask

  task automatic op_check(input string tag, input logic [232:0] ia, input logic [232:0] ib,
                          input logic [464:0] exp, input int inj_k);
    logic [464:0] got;
    int lat, nb;
    run_op(ia, ib, inj_k, got, lat, nb);
    check({tag, "_c"}, 512'(got), 512'(exp));
    check({tag, "_lat"}, 512'(lat), 512'(83));
    check({tag, "_busy"}, 512'(nb), 512'(82));
  endtask

  initial begin
    logic [464:0] sq1;
    logic [232:0] ra, rb;
    logic [255:0] tmp;
    int n_done;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", 512'({busy, done, mul_a, mul_b, c}), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);

    op_check("one", 233'd1, 233'd1, 465'd1, 0);
    @(negedge clk);
    check("done_pulse", 512'(done), 512'(0));

    op_check("top", 233'd1 << 232, 233'd1 << 232, 465'd1 << 464, 0);
    // (x+1)^2 = x^2 + 1
    op_check("x1sq", 233'd3, 233'd3, 465'd5, 0);
    // (x^29+1)(x^28+1) crosses a limb boundary
    op_check("xlimb", (233'd1 << 29) | 233'd1, (233'd1 << 28) | 233'd1,
             (465'd1 << 57) | (465'd1 << 29) | (465'd1 << 28) | 465'd1, 0);

    sq1 = '0;
    for (int unsigned i = 0; i <= 464; i += 2) sq1[i] = 1'b1;
    op_check("ones", '1, '1, sq1, 0);

    // Back-to-back: each op starts in the previous DONE cycle
    for (int t = 0; t < 12; t++) begin
      for (int w = 0; w < 8; w++) tmp[32*w +: 32] = $urandom;
      ra = tmp[232:0];
      for (int w = 0; w < 8; w++) tmp[32*w +: 32] = $urandom;
      rb = tmp[232:0];
      op_check($sformatf("rnd%0d", t), ra, rb, clmul233(ra, rb), 0);
    end
    @(negedge clk);

    // start during a busy run must be ignored
    op_check("ignore", 233'd3, (233'd1 << 100) | 233'd1,
             (465'd3 << 100) | 465'd3, 40);
    n_done = 0;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_extra_done", 512'(n_done), 512'(0));

    // Asynchronous reset mid-operation
    a = '1; b = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (48) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outs", 512'({busy, done, mul_a, mul_b, c}), 512'(0));
    rst_n = 1'b1;
    @(negedge clk);
    op_check("post_rst", 233'd3, 233'd3, 465'd5, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
